audio_serializer: RTL and testbench
===================================

AUDIO_SERIALIZER -- requirements
Module: audio_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the number of system clocks per BCLK half-period; legal values are 2 and above.
REQ-002 Parameter WIDTH, default 24, SHALL set the sample width in bits; slot width is fixed at 32 BCLKs.
REQ-003 clock  input  1  SHALL be the single system clock; all logic is clocked on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enable  input  1  SHALL request serial output to start (high) or stop (low).
REQ-006 sample_in  input  WIDTH  SHALL carry the two's-complement mixed sample from the mixer output, sampled only at frame start.
REQ-007 sample_req  output  1  SHALL pulse high for one clock in each cycle that sample_in is latched.
REQ-008 bclk  output  1  SHALL be the serial bit clock.
REQ-009 lrclk  output  1  SHALL be the word select: 0 selects the left slot, 1 selects the right slot.
REQ-010 sdata  output  1  SHALL be the serial data, MSB first, in I2S format.

Function
REQ-011 The state machine SHALL have three states: IDLE, RUN and DRAIN.
REQ-012 In IDLE, bclk, lrclk and sdata SHALL be held at 0, and the divider and slot counters SHALL be held at 0.
REQ-013 IDLE SHALL move to RUN on the first clock where enable=1. That same clock SHALL latch sample_in, pulse sample_req, and set slot index s=0.
REQ-014 In RUN and DRAIN, the divider SHALL count 0..CLK_DIV-1 and toggle bclk on the clock where the count equals CLK_DIV-1. The first rising edge of bclk SHALL occur CLK_DIV clocks after RUN is entered.
REQ-015 On each falling bclk toggle, s SHALL advance modulo 64. lrclk and sdata SHALL update in the same clock as that toggle.
REQ-016 lrclk SHALL be 0 for s=0..31 and 1 for s=32..63.
REQ-017 For k = s mod 32, sdata SHALL be latched_sample[WIDTH-k] for k=1..WIDTH, and 0 otherwise. This places the MSB one BCLK after each lrclk transition.
REQ-018 The same latched sample SHALL be sent in both the left and right slots (mono output).
REQ-019 On a falling toggle that wraps s from 63 to 0 in RUN, the block SHALL latch sample_in and pulse sample_req. The latched sample SHALL be stable for the whole frame.
REQ-020 In RUN, enable=0 SHALL move the block to DRAIN on the next clock. Output timing SHALL continue unchanged.
REQ-021 In DRAIN, enable=1 SHALL return the block to RUN with no gap and no disturbance to bclk, lrclk or s.
REQ-022 In DRAIN, the 63->0 wrap SHALL move the block to IDLE with bclk=0, lrclk=0 and sdata=0. No sample SHALL be latched and sample_req SHALL stay 0.
REQ-023 A frame SHALL be exactly 64 BCLKs, which is 128*CLK_DIV clocks. No partial frame SHALL appear on the outputs except when cut by reset.
REQ-024 Transitions SHALL be evaluated with priority reset > state logic. Simultaneous enable changes and wraps SHALL follow REQ-020 to REQ-022 according to the state held before the clock edge.

Reset
REQ-025 When reset=1 at a clock edge, the state SHALL become IDLE and all counters SHALL become 0. bclk, lrclk, sdata and sample_req SHALL be 0 after that edge and SHALL stay 0 while reset is held.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately. After reset is released, a new frame SHALL start only through REQ-013.

Verification
REQ-027 CLK_DIV=2, reset, then enable=1 with sample_in=24'hA5A5A5 -> sample_req pulses once in the RUN-entry clock. bclk period is 4 clocks. Left slot k=1..24 and right slot k=1..24 each carry 1010_0101 repeated three times. k=25..31 and k=0 carry 0.
REQ-028 Continuous enable, sample_in changed mid-frame from 24'h000001 to 24'h7FFFFF -> the current frame sends 24'h000001 in both slots. sample_req pulses exactly 256 clocks after the previous pulse. The next frame sends 24'h7FFFFF.
REQ-029 enable dropped at s=10 -> the frame completes through s=63, then the block enters IDLE with all outputs 0 and no sample_req pulse at the wrap.
REQ-030 enable dropped at s=10 and re-raised at s=40 -> there is no gap. sample_req pulses at the wrap and frames continue back to back.
REQ-031 reset pulsed for 1 clock at s=20 -> all outputs read 0 on the next clock. With enable held at 1, RUN is re-entered one clock after reset deasserts and a fresh frame starts at s=0.
REQ-032 sample_in=24'h800000 (most negative) -> sdata for k=1 is 1 and for k=2..24 is 0, in both slots.

Source files
------------

// File: rtl/audio_serializer_if.sv
// audio_serializer_if: mixer-side sample handshake plus the I2S output pins.
interface audio_serializer_if #(parameter int WIDTH = 24);
  logic             enable;
  logic [WIDTH-1:0] sample_in;
  logic             sample_req;
  logic             bclk;
  logic             lrclk;
  logic             sdata;
  modport master(output enable, sample_in, input sample_req, bclk, lrclk, sdata);
  modport slave(input enable, sample_in, output sample_req, bclk, lrclk, sdata);
endinterface

// File: rtl/audio_serializer.sv
// audio_serializer: mono I2S transmitter, 32-bit slots, one sample latched per 64-BCLK frame.
module audio_serializer #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 24
) (
  input logic               clock,
  input logic               reset,
  audio_serializer_if.slave io
);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state, state_n;
  logic [DW-1:0]    div;
  logic [5:0]       s;
  logic             bclk, req, tick, fall, wrap, latch;
  logic [WIDTH-1:0] sample;
  logic [31:0]      frame;
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (io.enable ? RUN : IDLE) :
              state == RUN  ? (io.enable ? RUN : DRAIN) :
              wrap          ? IDLE : (io.enable ? RUN : DRAIN);
  end
  // frame holds the slot image: bit 31 is the one-BCLK I2S delay, then MSB first.
  always_comb begin
    tick  = state != IDLE && div == DW'(CLK_DIV - 1);
    fall  = tick && bclk;
    wrap  = fall && s == 6'd63;
    latch = (state == IDLE && io.enable) || (state == RUN && wrap);
    frame = 32'(sample) << (31 - WIDTH);
  end
  always_ff @(posedge clock) begin
    if (reset || state == IDLE) begin
      div  <= '0;
      bclk <= 1'b0;
      s    <= '0;
    end else begin
      div  <= tick ? '0 : div + DW'(1);
      bclk <= bclk ^ tick;
      s    <= s + 6'(fall);
    end
    req <= !reset && latch;
    if (reset) sample <= '0;
    else if (latch) sample <= io.sample_in;
  end
  assign io.sample_req = req;
  assign io.bclk       = bclk;
  assign io.lrclk      = s[5];
  assign io.sdata      = frame[~s[4:0]];
endmodule

// File: tb/tb_audio_serializer.sv
// tb_audio_serializer: directed vectors plus frame-level sequences at CLK_DIV=2, WIDTH=24.
module tb_audio_serializer;
  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  audio_serializer_if #(.WIDTH(24)) io();
  audio_serializer #(.CLK_DIV(2), .WIDTH(24)) dut (.clock(clock), .reset(reset), .io(io));
  always #5 clock = ~clock;
  typedef struct {
    logic        rst;
    logic        en;
    logic [23:0] din;
    logic        req;
    logic        bclk;
    logic        lr;
    logic        sd;
  } vec_t;
  vec_t vt[11];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string name);
    chk({name, " req"}, 32'(io.sample_req), 0);
    chk({name, " bclk"}, 32'(io.bclk), 0);
    chk({name, " lrclk"}, 32'(io.lrclk), 0);
    chk({name, " sdata"}, 32'(io.sdata), 0);
  endtask
  // Walks one 256-clock frame starting right after the edge that began it.
  task automatic check_frame(input logic [23:0] exp, input logic [23:0] next_in,
                             input int drop_s, input int raise_s, input logic req0);
    for (int n = 0; n < 256; n++) begin
      int sl = n / 4;
      int k  = sl % 32;
      logic bit_exp = (k >= 1 && k <= 24) ? exp[24 - k] : 1'b0;
      chk($sformatf("req n=%0d", n), 32'(io.sample_req), 32'(n == 0 ? req0 : 1'b0));
      chk($sformatf("bclk n=%0d", n), 32'(io.bclk), 32'((n % 4) >= 2));
      if (n % 4 == 2) begin
        chk($sformatf("lrclk s=%0d", sl), 32'(io.lrclk), 32'(sl >= 32));
        chk($sformatf("sdata s=%0d", sl), 32'(io.sdata), 32'(bit_exp));
      end
      if (n == drop_s * 4) io.enable = 1'b0;
      if (n == raise_s * 4) io.enable = 1'b1;
      if (n == 100) io.sample_in = next_in;
      tick();
    end
  endtask
  initial begin
    vt[0]  = '{1, 0, 24'hA5A5A5, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 24'hA5A5A5, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 24'hA5A5A5, 1, 0, 0, 0};
    vt[3]  = '{0, 1, 24'h000000, 0, 0, 0, 0};
    vt[4]  = '{0, 1, 24'h000000, 0, 1, 0, 0};
    vt[5]  = '{0, 1, 24'h000000, 0, 1, 0, 0};
    vt[6]  = '{0, 1, 24'h000000, 0, 0, 0, 1};
    vt[7]  = '{0, 1, 24'h000000, 0, 0, 0, 1};
    vt[8]  = '{0, 1, 24'h000000, 0, 1, 0, 1};
    vt[9]  = '{0, 1, 24'h000000, 0, 1, 0, 1};
    vt[10] = '{0, 1, 24'h000000, 0, 0, 0, 0};
    reset = 1'b1;
    io.enable = 1'b0;
    io.sample_in = '0;
    tick();
    for (int i = 0; i < 11; i++) begin
      reset = vt[i].rst;
      io.enable = vt[i].en;
      io.sample_in = vt[i].din;
      tick();
      chk($sformatf("vec%0d req", i), 32'(io.sample_req), 32'(vt[i].req));
      chk($sformatf("vec%0d bclk", i), 32'(io.bclk), 32'(vt[i].bclk));
      chk($sformatf("vec%0d lrclk", i), 32'(io.lrclk), 32'(vt[i].lr));
      chk($sformatf("vec%0d sdata", i), 32'(io.sdata), 32'(vt[i].sd));
    end
    reset = 1'b1;
    io.enable = 1'b0;
    tick();
    reset = 1'b0;
    io.enable = 1'b1;
    io.sample_in = 24'hA5A5A5;
    tick();
    check_frame(24'hA5A5A5, 24'h000001, -1, -1, 1'b1);
    check_frame(24'h000001, 24'h7FFFFF, -1, -1, 1'b1);
    check_frame(24'h7FFFFF, 24'h800000, -1, -1, 1'b1);
    check_frame(24'h800000, 24'h123456, 10, 40, 1'b1);
    check_frame(24'h123456, 24'h000000, 10, -1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk_idle($sformatf("drained c%0d", i));
      tick();
    end
    io.sample_in = 24'hABCDEF;
    io.enable = 1'b1;
    tick();
    chk("restart req", 32'(io.sample_req), 1);
    repeat (80) tick();
    reset = 1'b1;
    tick();
    chk_idle("reset mid-frame");
    tick();
    chk_idle("reset held");
    reset = 1'b0;
    io.sample_in = 24'h5A5A5A;
    tick();
    check_frame(24'h5A5A5A, 24'h000000, 0, -1, 1'b1);
    chk_idle("final idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
